// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control slice: FSM states,
// opcodes and the ALU / operand / PC-source select codes.
package mc_cpu_pkg;

  typedef enum logic [3:0] {
    ST_INIT      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXEC      = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EX   = 4'd11,
    ST_I_WB      = 4'd12,
    ST_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_EXC    = 2'd3;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode dispatch for DECODE plus the load/store split used in
// MEM_ADDR. MC_CTRL_EXC_EN selects TRAP vs. FETCH (NOP) for illegal opcodes.
module mc_op_decode
  import mc_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  output state_t     dispatch,
  output logic       is_mem_load
);

  // Map the opcode onto the first execute-phase state
  always_comb begin
    dispatch    = ST_FETCH;
    is_mem_load = (opcode == OP_LW);
    case (opcode)
      OP_R:    dispatch = ST_EXEC;
      OP_LW:   dispatch = ST_MEM_ADDR;
      OP_SW:   dispatch = ST_MEM_ADDR;
      OP_BEQ:  dispatch = ST_BRANCH;
      OP_J:    dispatch = ST_JUMP;
      OP_ADDI: dispatch = ST_ADDI_EX;
`ifdef MC_CTRL_EXC_EN
      default: dispatch = ST_TRAP;
`else
      default: dispatch = ST_FETCH;
`endif
    endcase
  end

endmodule

// File: rtl/mc_cpu_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath. Define MC_CTRL_EXC_EN
// to build the TRAP state for illegal opcodes; otherwise they act as NOPs.
module mc_cpu_ctrl
  import mc_cpu_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_ce,
  output logic               ir_ce,
  output logic               mdr_ce,
  output logic               ab_ce,
  output logic               alu_out_ce,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               iord,
  output logic               reg_we,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               exc,
  output logic [STATE_W-1:0] state
);

  state_t state_r;
  state_t state_nxt_s;
  state_t dispatch_s;
  logic   is_mem_load_s;
  logic   mem_ok_s;

  assign mem_ok_s = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign state    = STATE_W'(state_r);

  mc_op_decode u_dec (
    .opcode      (opcode),
    .dispatch    (dispatch_s),
    .is_mem_load (is_mem_load_s)
  );

  // State register; rst pulls the FSM back to INIT without waiting for clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and state-decoded outputs, gated by mem_ready / zero only
  always_comb begin
    state_nxt_s = state_r;
    pc_ce       = 1'b0;
    ir_ce       = 1'b0;
    mdr_ce      = 1'b0;
    ab_ce       = 1'b0;
    alu_out_ce  = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    iord        = 1'b0;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    alu_op      = ALU_ADD;
    pc_src      = PCS_ALU;
    exc         = 1'b0;
    case (state_r)
      ST_INIT: state_nxt_s = ST_FETCH;
      ST_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_ce     = mem_ok_s;
        pc_ce     = mem_ok_s;
        if (mem_ok_s) begin
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ab_ce       = 1'b1;
        alu_out_ce  = 1'b1;
        alu_src_b   = SRCB_IMM_SH2;
        state_nxt_s = dispatch_s;
      end
      ST_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_out_ce  = 1'b1;
        state_nxt_s = is_mem_load_s ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        mdr_ce = mem_ok_s;
        if (mem_ok_s) begin
          state_nxt_s = ST_MEM_WB;
        end else begin
          state_nxt_s = ST_MEM_READ;
        end
      end
      ST_MEM_WB: begin
        reg_we      = 1'b1;
        mem_to_reg  = 1'b1;
        state_nxt_s = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ok_s) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_MEM_WRITE;
        end
      end
      ST_EXEC: begin
        alu_src_a   = 1'b1;
        alu_op      = ALU_FUNCT;
        alu_out_ce  = 1'b1;
        state_nxt_s = ST_R_WB;
      end
      ST_R_WB: begin
        reg_we      = 1'b1;
        reg_dst     = 1'b1;
        state_nxt_s = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op      = ALU_SUB;
        pc_src      = PCS_ALUOUT;
        pc_ce       = zero;
        state_nxt_s = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src      = PCS_JUMP;
        pc_ce       = 1'b1;
        state_nxt_s = ST_FETCH;
      end
      ST_ADDI_EX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_out_ce  = 1'b1;
        state_nxt_s = ST_I_WB;
      end
      ST_I_WB: begin
        reg_we      = 1'b1;
        state_nxt_s = ST_FETCH;
      end
`ifdef MC_CTRL_EXC_EN
      ST_TRAP: begin
        exc         = 1'b1;
        pc_src      = PCS_EXC;
        pc_ce       = 1'b1;
        state_nxt_s = ST_FETCH;
      end
`endif
      default: state_nxt_s = ST_INIT;
    endcase
  end

endmodule

// File: doc/mc_cpu_ctrl.md
Name: mc_cpu_ctrl

Overview:
- Moore-style control FSM for the multi-cycle 32-bit MIPS datapath.
- Sequences the clock enables of the datapath's 32-bit CE registers: PC, IR, MDR, A/B and ALUOut.
- Drives the mux selects, the register-file write and the memory strobes.
- Sits between the IR opcode field and the datapath; waits on a memory ready handshake.

Parameters:
- USE_MEM_READY, 1: when 1, memory states hold until mem_ready; when 0, mem_ready is ignored and memory states take one cycle.
- STATE_W, 4: width of the state register and of the state output.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_ce  out  1  PC register enable
- ir_ce  out  1  IR register enable
- mdr_ce  out  1  MDR register enable
- ab_ce  out  1  A/B register enable
- alu_out_ce  out  1  ALUOut register enable
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- reg_we  out  1  register-file write enable
- reg_dst  out  1  destination select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data select: 1 = MDR
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B operand: 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
- alu_op  out  2  0 = add, 1 = sub, 2 = funct-decoded
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = exception vector
- exc  out  1  illegal-opcode pulse
- state  out  STATE_W  current state, for debug

Behaviour:
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000.
- States and encodings:
  - INIT = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_READ = 4, MEM_WB = 5
  - MEM_WRITE = 6, EXEC = 7, R_WB = 8, BRANCH = 9, JUMP = 10, ADDI_EX = 11, I_WB = 12, TRAP = 13
- Reset:
  - rst forces INIT asynchronously.
  - In INIT every output is 0 except state = 0.
  - INIT -> FETCH unconditionally on the next clock.
- Outputs:
  - Decoded from state only, except for the gating below.
  - pc_ce, ir_ce and mdr_ce are gated by mem_ready in memory states.
  - pc_ce is gated by zero in BRANCH.
  - Every enable not listed for a state is 0.
- FETCH:
  - mem_rd = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = 0, pc_src = 0.
  - ir_ce = pc_ce = mem_ready.
  - Stays in FETCH until mem_ready, then -> DECODE.
- DECODE:
  - ab_ce = 1, alu_out_ce = 1, alu_src_a = 0, alu_src_b = 3, alu_op = 0 (branch target into ALUOut).
  - Next state by opcode: R -> EXEC, LW/SW -> MEM_ADDR, BEQ -> BRANCH, J -> JUMP, ADDI -> ADDI_EX.
  - Any other opcode -> TRAP.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = 0, alu_out_ce = 1. Next: LW -> MEM_READ, SW -> MEM_WRITE.
- MEM_READ: mem_rd = 1, iord = 1, mdr_ce = mem_ready. Holds until mem_ready, then -> MEM_WB.
- MEM_WB: reg_we = 1, reg_dst = 0, mem_to_reg = 1. -> FETCH.
- MEM_WRITE: mem_wr = 1, iord = 1. Holds until mem_ready, then -> FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 0, alu_op = 2, alu_out_ce = 1. -> R_WB.
- R_WB: reg_we = 1, reg_dst = 1, mem_to_reg = 0. -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = 1, pc_src = 1, pc_ce = zero. -> FETCH.
- JUMP: pc_src = 2, pc_ce = 1. -> FETCH.
- ADDI_EX: alu_src_a = 1, alu_src_b = 2, alu_op = 0, alu_out_ce = 1. -> I_WB.
- I_WB: reg_we = 1, reg_dst = 0, mem_to_reg = 0. -> FETCH.
- Latency in cycles, with zero-wait memory, counted from FETCH entry to the next FETCH entry: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4.
- Wait states: every wait cycle keeps the state's outputs steady, and mem_rd/mem_wr stay asserted until mem_ready.
- Mid-instruction reset: rst asserted in any state, including during a memory wait, returns to INIT immediately. No partial register-file write, memory write or PC update occurs after rst rises.
- opcode is sampled only in DECODE, MEM_ADDR and the I/R paths. It is valid because IR is held (ir_ce = 0) outside FETCH.

Optional Feature:
- Macro MC_CTRL_EXC_EN.
- Defined: an illegal opcode -> TRAP. TRAP asserts exc = 1, pc_src = 3 and pc_ce = 1 for one cycle, then -> FETCH.
- Not defined: an illegal opcode is a NOP. DECODE -> FETCH directly, the TRAP state is not built, and exc is tied to 0.

Decomposition:
- Shared package mc_cpu_pkg:
  - state encodings
  - opcode constants
  - alu_op, alu_src_b and pc_src encodings
- One sub-module, mc_op_decode: combinational opcode -> dispatch state for DECODE, with an is_mem_load flag for MEM_ADDR.

Test Plan:
- rst held 3 cycles, then released:
  - state = 0 with all outputs 0 while held.
  - state = 1 and mem_rd = 1 one cycle after release.
- R-type (opcode 000000), mem_ready tied 1: states 1, 2, 7, 8, 1. reg_we = 1 and reg_dst = 1 only in state 8. Total 4 cycles.
- LW (opcode 100011) with mem_ready low 2 cycles in MEM_READ:
  - State 4 lasts 3 cycles with mem_rd = 1 and iord = 1.
  - mdr_ce = 1 only on the last of those cycles.
  - Then state 5 with mem_to_reg = 1.
- BEQ (opcode 000100): zero = 1 gives pc_ce = 1 and pc_src = 1 in state 9; zero = 0 gives pc_ce = 0. Both return to FETCH.
- Opcode 111111:
  - With MC_CTRL_EXC_EN: state 13, exc = 1, pc_src = 3, pc_ce = 1, then FETCH.
  - Without: DECODE -> FETCH and exc stays 0.
- SW (opcode 101011) with rst asserted in MEM_WRITE while mem_ready = 0: state becomes 0 asynchronously, mem_wr drops that cycle and reg_we never asserts.
